// File: rtl/fpnew_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fpnew_pkg
// Purpose : Shared FPU types used by the lane serializer and its neighbours:
//           IEEE exception flags, rounding modes and operation encodings.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package fpnew_pkg;

    // Exception flags, NX in the LSB.
    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        ROD = 3'b101,
        DYN = 3'b111
    } roundmode_e;

    typedef enum logic [3:0] {
        FMADD    = 4'd0,
        FNMSUB   = 4'd1,
        ADD      = 4'd2,
        MUL      = 4'd3,
        DIV      = 4'd4,
        SQRT     = 4'd5,
        SGNJ     = 4'd6,
        MINMAX   = 4'd7,
        CMP      = 4'd8,
        CLASSIFY = 4'd9,
        F2F      = 4'd10,
        F2I      = 4'd11,
        I2F      = 4'd12,
        CPKAB    = 4'd13,
        CPKCD    = 4'd14
    } operation_e;

endpackage
`default_nettype wire

// File: rtl/fpnew_lane_serializer.sv
`default_nettype none
// ============================================================================
// Module  : fpnew_lane_serializer
// Purpose : Accepts one packed (possibly SIMD) FP operation, feeds its lanes
//           one at a time through a single scalar lane unit, and reassembles
//           the packed result with OR-accumulated status of unmasked lanes.
// Ports   : clk_i/rst_i            clock, synchronous active-high reset
//           operands_i..flush_i    upstream operation handshake + flush
//           result_o..busy_o       packed result handshake, busy flag
//           lane_*_o / lane_*_i    request/response to the scalar lane unit
// Rev     : 1.0  initial release
// ============================================================================
module fpnew_lane_serializer
    import fpnew_pkg::*;
#(
    parameter int  Width       = 32,
    parameter int  FpWidth     = 16,
    parameter int  NumOperands = 3,
    parameter type TagType     = logic
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    // upstream
    input  logic [NumOperands-1:0][Width-1:0]      operands_i,
    input  logic [NumOperands-1:0]                 is_boxed_i,
    input  roundmode_e                             rnd_mode_i,
    input  operation_e                             op_i,
    input  logic                                   op_mod_i,
    input  logic                                   vectorial_op_i,
    input  TagType                                 tag_i,
    input  logic [Width/FpWidth-1:0]               simd_mask_i,
    input  logic                                   in_valid_i,
    output logic                                   in_ready_o,
    input  logic                                   flush_i,
    // result
    output logic [Width-1:0]                       result_o,
    output status_t                                status_o,
    output logic                                   extension_bit_o,
    output TagType                                 tag_o,
    output logic                                   out_valid_o,
    input  logic                                   out_ready_i,
    output logic                                   busy_o,
    // lane unit
    output logic [NumOperands-1:0][FpWidth-1:0]    lane_operands_o,
    output logic [NumOperands-1:0]                 lane_is_boxed_o,
    output roundmode_e                             lane_rnd_mode_o,
    output operation_e                             lane_op_o,
    output logic                                   lane_op_mod_o,
    output logic                                   lane_valid_o,
    input  logic                                   lane_ready_i,
    output logic                                   lane_flush_o,
    input  logic [FpWidth-1:0]                     lane_result_i,
    input  status_t                                lane_status_i,
    input  logic                                   lane_ext_bit_i,
    input  logic                                   lane_valid_i,
    output logic                                   lane_ready_o
);

    localparam int NUM_LANES = Width / FpWidth;
    localparam int IDX_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int LANES_W   = NUM_LANES * FpWidth;
    localparam int PAD_W     = Width - LANES_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e                               r_state;
    state_e                               w_state_nxt;

    logic [NumOperands-1:0][Width-1:0]    r_operands;
    logic [NumOperands-1:0]               r_is_boxed;
    roundmode_e                           r_rnd_mode;
    operation_e                           r_op;
    logic                                 r_op_mod;
    logic                                 r_vectorial;
    TagType                               r_tag;
    logic [NUM_LANES-1:0]                 r_simd_mask;
    logic [IDX_W-1:0]                     r_lane_idx;
    status_t                              r_status;
    logic                                 r_ext;
    logic [NUM_LANES-1:0][FpWidth-1:0]    r_slots;

    logic                                 w_accept;
    logic                                 w_lane_done;
    logic                                 w_is_last;
    logic [IDX_W-1:0]                     w_last_idx;
    logic [31:0]                          w_lane_base;
    logic [LANES_W-1:0]                   w_lanes;

    // Scalar operations only ever use lane 0.
    assign w_last_idx  = r_vectorial ? IDX_W'(NUM_LANES - 1) : '0;
    assign w_is_last   = (r_lane_idx == w_last_idx);
    assign w_accept    = in_ready_o & in_valid_i;
    assign w_lane_done = lane_ready_o & lane_valid_i;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)     w_state_nxt = ST_ISSUE;
            ST_ISSUE: if (lane_ready_i) w_state_nxt = ST_WAIT;
            ST_WAIT:  if (w_lane_done)  w_state_nxt = w_is_last ? ST_DONE : ST_ISSUE;
            ST_DONE:  if (out_ready_i)  w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
        // Flush overrides everything, including an in-flight lane response.
        if (flush_i) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs (handshakes are gated by flush so nothing is accepted
    // or produced in the cycle the pipeline is being emptied)
    // ------------------------------------------------------------------
    always_comb begin
        in_ready_o   = (r_state == ST_IDLE)  & ~flush_i;
        lane_valid_o = (r_state == ST_ISSUE) & ~flush_i;
        lane_ready_o = (r_state == ST_WAIT)  & ~flush_i;
        out_valid_o  = (r_state == ST_DONE)  & ~flush_i;
        busy_o       = (r_state != ST_IDLE);
    end

    assign lane_flush_o = flush_i;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_operands  <= '0;
            r_is_boxed  <= '0;
            r_rnd_mode  <= RNE;
            r_op        <= FMADD;
            r_op_mod    <= 1'b0;
            r_vectorial <= 1'b0;
            r_tag       <= '0;
            r_simd_mask <= '0;
            r_lane_idx  <= '0;
            r_status    <= '0;
            r_ext       <= 1'b0;
            r_slots     <= '0;
        end else if (flush_i) begin
            r_lane_idx  <= '0;
            r_status    <= '0;
        end else begin
            if (w_accept) begin
                r_operands  <= operands_i;
                r_is_boxed  <= is_boxed_i;
                r_rnd_mode  <= rnd_mode_i;
                r_op        <= op_i;
                r_op_mod    <= op_mod_i;
                r_vectorial <= vectorial_op_i;
                r_tag       <= tag_i;
                r_simd_mask <= simd_mask_i;
                r_lane_idx  <= '0;
                r_status    <= '0;
            end
            if (w_lane_done) begin
                r_slots[r_lane_idx] <= lane_result_i;
                // Masked lanes are computed but must not raise flags.
                if (r_simd_mask[r_lane_idx]) begin
                    r_status <= r_status | lane_status_i;
                end
                if (r_lane_idx == '0) begin
                    r_ext <= lane_ext_bit_i;
                end
                if (!w_is_last) begin
                    r_lane_idx <= r_lane_idx + IDX_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Lane request: slice of each captured operand for the current lane
    // ------------------------------------------------------------------
    assign w_lane_base = 32'(r_lane_idx) * 32'(FpWidth);

    always_comb begin
        lane_operands_o = '0;
        for (int k = 0; k < NumOperands; k++) begin
            lane_operands_o[k] = r_operands[k][w_lane_base +: FpWidth];
        end
    end

    assign lane_is_boxed_o = r_is_boxed;
    assign lane_rnd_mode_o = r_rnd_mode;
    assign lane_op_o       = r_op;
    assign lane_op_mod_o   = r_op_mod;

    // ------------------------------------------------------------------
    // Result assembly: lanes never issued (scalar op) are filled with the
    // lane-0 extension bit so the scalar result comes out NaN-boxed.
    // ------------------------------------------------------------------
    always_comb begin
        w_lanes = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (r_vectorial || (i == 0)) begin
                w_lanes[i*FpWidth +: FpWidth] = r_slots[i];
            end else begin
                w_lanes[i*FpWidth +: FpWidth] = {FpWidth{r_ext}};
            end
        end
    end

    generate
        if (PAD_W > 0) begin : g_pad
            assign result_o = {{PAD_W{r_ext}}, w_lanes};
        end else begin : g_nopad
            assign result_o = w_lanes;
        end
    endgenerate

    assign status_o        = r_status;
    assign extension_bit_o = r_ext;
    assign tag_o           = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_fpnew_lane_serializer.sv
`default_nettype none
// ============================================================================
// Module  : tb_fpnew_lane_serializer
// Purpose : Directed, table-driven self-checking bench for the lane
//           serializer (Width=32, FpWidth=16) with a zero/stalled-wait lane
//           unit model, plus flush and reset corner sequences.
// Rev     : 1.0  initial release
// ============================================================================
module tb_fpnew_lane_serializer;
    import fpnew_pkg::*;

    localparam int W  = 32;
    localparam int FW = 16;
    localparam int NO = 3;
    localparam int NL = W / FW;

    logic                       clk_i = 1'b0;
    logic                       rst_i;
    logic [NO-1:0][W-1:0]       operands_i;
    logic [NO-1:0]              is_boxed_i;
    roundmode_e                 rnd_mode_i;
    operation_e                 op_i;
    logic                       op_mod_i;
    logic                       vectorial_op_i;
    logic                       tag_i;
    logic [NL-1:0]              simd_mask_i;
    logic                       in_valid_i;
    logic                       in_ready_o;
    logic                       flush_i;
    logic [W-1:0]               result_o;
    status_t                    status_o;
    logic                       extension_bit_o;
    logic                       tag_o;
    logic                       out_valid_o;
    logic                       out_ready_i;
    logic                       busy_o;
    logic [NO-1:0][FW-1:0]      lane_operands_o;
    logic [NO-1:0]              lane_is_boxed_o;
    roundmode_e                 lane_rnd_mode_o;
    operation_e                 lane_op_o;
    logic                       lane_op_mod_o;
    logic                       lane_valid_o;
    logic                       lane_ready_i;
    logic                       lane_flush_o;
    logic [FW-1:0]              lane_result_i;
    status_t                    lane_status_i;
    logic                       lane_ext_bit_i;
    logic                       lane_valid_i;
    logic                       lane_ready_o;

    fpnew_lane_serializer #(
        .Width       (W),
        .FpWidth     (FW),
        .NumOperands (NO),
        .TagType     (logic)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .operands_i      (operands_i),
        .is_boxed_i      (is_boxed_i),
        .rnd_mode_i      (rnd_mode_i),
        .op_i            (op_i),
        .op_mod_i        (op_mod_i),
        .vectorial_op_i  (vectorial_op_i),
        .tag_i           (tag_i),
        .simd_mask_i     (simd_mask_i),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .flush_i         (flush_i),
        .result_o        (result_o),
        .status_o        (status_o),
        .extension_bit_o (extension_bit_o),
        .tag_o           (tag_o),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .busy_o          (busy_o),
        .lane_operands_o (lane_operands_o),
        .lane_is_boxed_o (lane_is_boxed_o),
        .lane_rnd_mode_o (lane_rnd_mode_o),
        .lane_op_o       (lane_op_o),
        .lane_op_mod_o   (lane_op_mod_o),
        .lane_valid_o    (lane_valid_o),
        .lane_ready_i    (lane_ready_i),
        .lane_flush_o    (lane_flush_o),
        .lane_result_i   (lane_result_i),
        .lane_status_i   (lane_status_i),
        .lane_ext_bit_i  (lane_ext_bit_i),
        .lane_valid_i    (lane_valid_i),
        .lane_ready_o    (lane_ready_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [NO-1:0][W-1:0]   ops;
        logic                   vec;
        logic [NL-1:0]          mask;
        logic [NL-1:0][FW-1:0]  res;   // lane unit answers, lane 0 first
        logic [NL-1:0][4:0]     st;
        logic [NL-1:0]          ext;
        logic                   tag;
        logic [W-1:0]           exp_res;
        logic [4:0]             exp_st;
        logic                   exp_ext;
        int                     exp_lat;
        int                     exp_iss;
    } vec_t;

    vec_t vecs [6];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid_i     = 1'b0;
        flush_i        = 1'b0;
        out_ready_i    = 1'b0;
        lane_ready_i   = 1'b0;
        lane_valid_i   = 1'b0;
        lane_result_i  = '0;
        lane_status_i  = '0;
        lane_ext_bit_i = 1'b0;
    endtask

    task automatic drive_op(input vec_t v);
        operands_i     = v.ops;
        vectorial_op_i = v.vec;
        simd_mask_i    = v.mask;
        tag_i          = v.tag;
        op_mod_i       = v.tag;
        is_boxed_i     = 3'b101;
        rnd_mode_i     = RMM;
        op_i           = MUL;
    endtask

    // One full operation. lstall: cycles lane_ready_i stays low on the first
    // issue; ostall: cycles out_ready_i stays low once the result is offered.
    task automatic run_vec(input vec_t v, input int lstall, input int ostall);
        int k, n_iss, n_rsp, n_out, ls, os;
        bit done;
        logic [NO-1:0][FW-1:0] e_ops;
        logic [W-1:0]          e_word;
        @(negedge clk_i);
        drive_op(v);
        in_valid_i = 1'b1;
        #1 chk("in_ready", in_ready_o, 1'b1);
        @(posedge clk_i);
        k = 0; n_iss = 0; n_rsp = 0; n_out = 0; ls = lstall; os = ostall; done = 0;
        while (!done && k < 60) begin
            @(negedge clk_i);
            k++;
            in_valid_i   = 1'b0;
            lane_valid_i = 1'b0;
            out_ready_i  = 1'b0;
            lane_ready_i = 1'b0;
            #1;
            if (lane_valid_o) begin
                for (int j = 0; j < NO; j++) begin
                    e_word   = v.ops[j];
                    e_ops[j] = e_word[n_iss*FW +: FW];
                end
                chk("lane_ops", lane_operands_o, e_ops);
                chk("lane_ctl", {lane_is_boxed_o, lane_rnd_mode_o, lane_op_o, lane_op_mod_o},
                    {3'b101, RMM, MUL, v.tag});
                if (ls > 0) begin
                    ls--;
                end else begin
                    lane_ready_i = 1'b1;
                    n_iss++;
                end
            end
            if (lane_ready_o && n_rsp < NL) begin
                lane_valid_i   = 1'b1;
                lane_result_i  = v.res[n_rsp];
                lane_status_i  = status_t'(v.st[n_rsp]);
                lane_ext_bit_i = v.ext[n_rsp];
                n_rsp++;
            end
            if (out_valid_o) begin
                n_out++;
                if (n_out == 1) chk("latency", k, v.exp_lat + lstall);
                chk("result", result_o, v.exp_res);
                chk("status", status_o, v.exp_st);
                chk("ext_bit", extension_bit_o, v.exp_ext);
                chk("tag", tag_o, v.tag);
                if (os > 0) begin
                    os--;
                end else begin
                    out_ready_i = 1'b1;
                    done = 1;
                end
            end
        end
        if (!done) chk("out_timeout", 1'b0, 1'b1);
        chk("issue_count", n_iss, v.exp_iss);
        chk("out_count", n_out, ostall + 1);
        @(negedge clk_i);
        idle_inputs();
        #1;
        chk("post_out_valid", out_valid_o, 1'b0);
        chk("post_in_ready", in_ready_o, 1'b1);
    endtask

    initial begin
        int  k, bad;
        bit  seen;

        // name: scalar NaN-box
        vecs[0] = '{ops: {32'h0000BEEF, 32'hAAAA3C00, 32'h12345678}, vec: 1'b0, mask: 2'b11,
                    res: {16'h0000, 16'h3C00}, st: {5'b00000, 5'b00000}, ext: 2'b01, tag: 1'b1,
                    exp_res: 32'hFFFF3C00, exp_st: 5'b00000, exp_ext: 1'b1, exp_lat: 3, exp_iss: 1};
        // vector both lanes enabled
        vecs[1] = '{ops: {32'h11112222, 32'h33334444, 32'h55556666}, vec: 1'b1, mask: 2'b11,
                    res: {16'h4200, 16'h4000}, st: {5'b00001, 5'b00000}, ext: 2'b00, tag: 1'b0,
                    exp_res: 32'h42004000, exp_st: 5'b00001, exp_ext: 1'b0, exp_lat: 5, exp_iss: 2};
        // lane 1 masked: its flags dropped
        vecs[2] = '{ops: {32'hCAFEF00D, 32'h0BADBEEF, 32'hFEEDFACE}, vec: 1'b1, mask: 2'b01,
                    res: {16'h2222, 16'h1111}, st: {5'b10000, 5'b00000}, ext: 2'b00, tag: 1'b1,
                    exp_res: 32'h22221111, exp_st: 5'b00000, exp_ext: 1'b0, exp_lat: 5, exp_iss: 2};
        // scalar, ext 0 -> zero upper half
        vecs[3] = '{ops: {32'h00010002, 32'h00030004, 32'h00050006}, vec: 1'b0, mask: 2'b01,
                    res: {16'h0000, 16'h7E00}, st: {5'b00000, 5'b00100}, ext: 2'b00, tag: 1'b0,
                    exp_res: 32'h00007E00, exp_st: 5'b00100, exp_ext: 1'b0, exp_lat: 3, exp_iss: 1};
        // lane 0 masked, ext from lane 0 only
        vecs[4] = '{ops: {32'h89ABCDEF, 32'h01234567, 32'h76543210}, vec: 1'b1, mask: 2'b10,
                    res: {16'h1234, 16'hABCD}, st: {5'b00010, 5'b01000}, ext: 2'b01, tag: 1'b0,
                    exp_res: 32'h1234ABCD, exp_st: 5'b00010, exp_ext: 1'b1, exp_lat: 5, exp_iss: 2};
        // scalar fully masked
        vecs[5] = '{ops: {32'hFFFFFFFF, 32'h80000001, 32'h7FFF8000}, vec: 1'b0, mask: 2'b00,
                    res: {16'h0000, 16'h0001}, st: {5'b00000, 5'b11111}, ext: 2'b01, tag: 1'b1,
                    exp_res: 32'hFFFF0001, exp_st: 5'b00000, exp_ext: 1'b1, exp_lat: 3, exp_iss: 1};

        idle_inputs();
        drive_op(vecs[0]);
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        #1;
        chk("rst_in_ready", in_ready_o, 1'b1);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_out_valid", out_valid_o, 1'b0);
        chk("rst_lane_valid", lane_valid_o, 1'b0);
        chk("rst_lane_ready", lane_ready_o, 1'b0);
        rst_i = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], 0, 0);
        end

        // Back-pressure on both sides.
        run_vec(vecs[1], 3, 2);

        // Flush while waiting for the lane response.
        @(negedge clk_i);
        drive_op(vecs[1]);
        in_valid_i = 1'b1;
        @(posedge clk_i);
        k = 0; seen = 0;
        while (!seen && k < 20) begin
            @(negedge clk_i);
            k++;
            in_valid_i   = 1'b0;
            lane_ready_i = 1'b1;
            #1;
            if (lane_ready_o) seen = 1;
        end
        chk("flush_reach_wait", seen, 1'b1);
        chk("flush_idle_low", lane_flush_o, 1'b0);
        flush_i        = 1'b1;
        lane_valid_i   = 1'b1;
        lane_result_i  = 16'hDEAD;
        #1;
        chk("flush_comb", lane_flush_o, 1'b1);
        chk("flush_out_valid", out_valid_o, 1'b0);
        @(negedge clk_i);
        idle_inputs();
        #1;
        chk("flush_busy", busy_o, 1'b0);
        chk("flush_in_ready", in_ready_o, 1'b1);
        bad = 0;
        repeat (8) begin
            @(negedge clk_i);
            #1;
            if (out_valid_o || lane_valid_o) bad++;
        end
        chk("flush_quiet", bad, 0);

        // Reset during issue.
        @(negedge clk_i);
        drive_op(vecs[2]);
        in_valid_i = 1'b1;
        @(posedge clk_i);
        k = 0; seen = 0;
        while (!seen && k < 20) begin
            @(negedge clk_i);
            k++;
            in_valid_i   = 1'b0;
            lane_ready_i = 1'b0;
            #1;
            if (lane_valid_o) seen = 1;
        end
        chk("rst_reach_issue", seen, 1'b1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rst_mid_in_ready", in_ready_o, 1'b1);
        chk("rst_mid_busy", busy_o, 1'b0);
        chk("rst_mid_lane_valid", lane_valid_o, 1'b0);
        bad = 0;
        repeat (8) begin
            @(negedge clk_i);
            #1;
            if (out_valid_o || lane_valid_o) bad++;
        end
        chk("rst_quiet", bad, 0);

        // Recovery after reset.
        run_vec(vecs[3], 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
